// File: rtl/alu_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: operation and
// set-type codes, FSM state encoding, control bundle and set-bit select.
package alu_serial_seq_pkg;

    // Operation field of alu_ctrl
    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;
    localparam logic [1:0] OP_SET = 2'd3;

    // Set-type select (bonus_ctrl)
    localparam logic [2:0] SET_LT = 3'd0;
    localparam logic [2:0] SET_GT = 3'd1;
    localparam logic [2:0] SET_LE = 3'd2;
    localparam logic [2:0] SET_GE = 3'd3;
    localparam logic [2:0] SET_EQ = 3'd4;
    localparam logic [2:0] SET_NE = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Bit layout matches alu_ctrl_i: {A_invert, B_invert, operation[1:0]}
    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic [1:0] op;
    } alu_ctrl_t;

    // Reduce the less/equal pair to the single set bit chosen by bonus.
    // Codes 6 and 7 yield 0.
    function automatic logic set_select(input logic       less,
                                        input logic       equal,
                                        input logic [2:0] bonus);
        logic set_bit;
        set_bit = 1'b0;
        case (bonus)
            SET_LT:  set_bit = less;
            SET_GT:  set_bit = ~less & ~equal;
            SET_LE:  set_bit = less | equal;
            SET_GE:  set_bit = ~less;
            SET_EQ:  set_bit = equal;
            SET_NE:  set_bit = ~equal;
            default: set_bit = 1'b0;
        endcase
        return set_bit;
    endfunction

endpackage

// File: rtl/serial_bit_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, AND/OR/add.
// Carry-out and raw sum are always produced so the sequencer can run the
// add path for set-type operations.
module serial_bit_slice
    import alu_serial_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       a_inv,
    input  logic       b_inv,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       res,
    output logic       cout,
    output logic       sum
);

    logic a_eff;
    logic b_eff;

    assign a_eff = a ^ a_inv;
    assign b_eff = b ^ b_inv;
    assign sum   = a_eff ^ b_eff ^ cin;
    assign cout  = (a_eff & b_eff) | (cin & (a_eff ^ b_eff));

    // Result bit per operation; set-type is resolved by the sequencer at the MSB
    always_comb begin
        res = 1'b0;
        unique case (op)
            OP_AND: res = a_eff & b_eff;
            OP_OR:  res = a_eff | b_eff;
            OP_ADD: res = sum;
            OP_SET: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer. Time-multiplexes a single serial_bit_slice over
// WIDTH cycles (LSB first) and assembles the WIDTH-bit result plus flags.
// Result and flags change only on the RUN->DONE edge and are held otherwise.
module alu_serial_seq
    import alu_serial_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       alu_ctrl_i,
    input  logic [2:0]       bonus_ctrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    state_e           state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic             eq_acc_q, eq_acc_d;
    logic [WIDTH-1:0] src_a_q,  src_a_d;
    logic [WIDTH-1:0] src_b_q,  src_b_d;
    alu_ctrl_t        ctrl_q,   ctrl_d;
    logic [2:0]       bonus_q,  bonus_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic slice_a;
    logic slice_b;
    logic slice_res;
    logic slice_cout;
    logic slice_sum;
    logic last_bit;
    logic less;
    logic equal;
    logic set_bit;

    assign slice_a  = src_a_q[idx_q];
    assign slice_b  = src_b_q[idx_q];
    assign last_bit = (idx_q == IDX_W'(WIDTH - 1));

    serial_bit_slice u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .a_inv (ctrl_q.a_inv),
        .b_inv (ctrl_q.b_inv),
        .cin   (carry_q),
        .op    (ctrl_q.op),
        .res   (slice_res),
        .cout  (slice_cout),
        .sum   (slice_sum)
    );

    // MSB-stage compare terms: carry_q is the carry into the MSB, slice_cout
    // the carry out of it; their XOR corrects the sign bit on overflow.
    always_comb begin
        less    = slice_sum ^ (carry_q ^ slice_cout);
        equal   = eq_acc_q & ~slice_sum;
        set_bit = set_select(less, equal, bonus_q);
    end

    // Next-state: accept, per-bit stepping and final capture of result/flags
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        eq_acc_d = eq_acc_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        ctrl_d   = ctrl_q;
        bonus_d  = bonus_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_a_d  = src1_i;
                    src_b_d  = src2_i;
                    ctrl_d   = alu_ctrl_t'(alu_ctrl_i);
                    bonus_d  = bonus_ctrl_i;
                    // B inversion plus carry-in 1 forms two's-complement a-b
                    carry_d  = alu_ctrl_i[2];
                    idx_d    = '0;
                    acc_d    = '0;
                    eq_acc_d = 1'b1;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                carry_d = slice_cout;
                if (ctrl_q.op == OP_SET) begin
                    eq_acc_d = eq_acc_q & ~slice_sum;
                end else begin
                    acc_d[idx_q] = slice_res;
                end

                if (last_bit) begin
                    state_d = S_DONE;
                    if (ctrl_q.op == OP_SET) begin
                        result_d = {{(WIDTH - 1){1'b0}}, set_bit};
                    end else begin
                        result_d = acc_d;
                    end
                    cout_d = (ctrl_q.op == OP_ADD || ctrl_q.op == OP_SET) ? slice_cout : 1'b0;
                    ovf_d  = (ctrl_q.op == OP_ADD) ? (carry_q ^ slice_cout) : 1'b0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_DONE: begin
                // start_i here is deliberately ignored; acceptance is from IDLE only
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            eq_acc_q <= 1'b0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            ctrl_q   <= '0;
            bonus_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            eq_acc_q <= eq_acc_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            ctrl_q   <= ctrl_d;
            bonus_q  <= bonus_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Status and held outputs
    always_comb begin
        busy_o     = (state_q != S_IDLE);
        done_o     = (state_q == S_DONE);
        result_o   = result_q;
        zero_o     = (result_q == '0);
        cout_o     = cout_q;
        overflow_o = ovf_q;
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: directed cases with literal expectations plus
// randomized operations checked against an arithmetic reference model.
module tb_alu_serial_seq;

    localparam int unsigned W  = 32;
    localparam int unsigned IW = 5;

    typedef struct packed {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [W-1:0] src1_i;
    logic [W-1:0] src2_i;
    logic [3:0]   alu_ctrl_i;
    logic [2:0]   bonus_ctrl_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         cout_o;
    logic         overflow_o;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    alu_serial_seq #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .src1_i       (src1_i),
        .src2_i       (src2_i),
        .alu_ctrl_i   (alu_ctrl_i),
        .bonus_ctrl_i (bonus_ctrl_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .result_o     (result_o),
        .zero_o       (zero_o),
        .cout_o       (cout_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: whole-word arithmetic on the (optionally inverted) operands
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] ctrl, input logic [2:0] bonus);
        logic [W-1:0] ai, bi, sum;
        logic [W:0]   full;
        logic         c_in_msb, c_out, less, equal, set_bit;
        exp_t         e;
        ai       = ctrl[3] ? ~a : a;
        bi       = ctrl[2] ? ~b : b;
        full     = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, ctrl[2]};
        sum      = full[W-1:0];
        c_out    = full[W];
        c_in_msb = ai[W-1] ^ bi[W-1] ^ sum[W-1];
        less     = sum[W-1] ^ (c_in_msb ^ c_out);
        equal    = (sum == '0);
        case (bonus)
            3'd0:    set_bit = less;
            3'd1:    set_bit = !less && !equal;
            3'd2:    set_bit = less || equal;
            3'd3:    set_bit = !less;
            3'd4:    set_bit = equal;
            3'd5:    set_bit = !equal;
            default: set_bit = 1'b0;
        endcase
        e = '0;
        case (ctrl[1:0])
            2'd0: e.res = ai & bi;
            2'd1: e.res = ai | bi;
            2'd2: begin
                e.res  = sum;
                e.cout = c_out;
                e.ovf  = c_in_msb ^ c_out;
            end
            default: begin
                e.res  = {{(W - 1){1'b0}}, set_bit};
                e.cout = c_out;
            end
        endcase
        return e;
    endfunction

    // Compare process: outputs hold the last completed result, and each
    // done_o must retire exactly one queued expectation.
    initial begin
        exp_t held;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = '0;
                check("done_in_reset", {31'd0, done_o}, '0);
            end else begin
                if (done_o) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_done", 32'd1, 32'd0);
                    end else begin
                        held = exp_q.pop_front();
                    end
                end
                check("result", result_o, held.res);
                check("zero", {31'd0, zero_o}, {31'd0, held.res == '0});
                check("cout", {31'd0, cout_o}, {31'd0, held.cout});
                check("overflow", {31'd0, overflow_o}, {31'd0, held.ovf});
            end
        end
    end

    // Issue one operation and time its completion. lit_en adds literal checks;
    // poke injects a start_i with src1=0 mid-run, which must be ignored.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] ctrl, input logic [2:0] bonus,
                         input bit lit_en, input logic [W-1:0] lit_res,
                         input logic lit_cout, input logic lit_ovf, input bit poke);
        int n;
        int guard;
        bit seen;
        guard = 0;
        @(negedge clk);
        while (busy_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy_o) check("idle_timeout", 32'd1, 32'd0);
        src1_i       = a;
        src2_i       = b;
        alu_ctrl_i   = ctrl;
        bonus_ctrl_i = bonus;
        start_i      = 1'b1;
        exp_q.push_back(model(a, b, ctrl, bonus));
        @(posedge clk);
        #1;
        start_i      = 1'b0;
        // Scramble inputs: the latched copies must be used
        src1_i       = $urandom;
        src2_i       = $urandom;
        alu_ctrl_i   = 4'($urandom);
        bonus_ctrl_i = 3'($urandom);
        check("busy_after_accept", {31'd0, busy_o}, 32'd1);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < W + 4) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 10) begin
                start_i = 1'b1;
                src1_i  = '0;
            end else if (poke && n == 11) begin
                start_i = 1'b0;
            end
            if (done_o) seen = 1'b1;
        end
        check("done_latency", n, W);
        if (seen) begin
            check("busy_at_done", {31'd0, busy_o}, 32'd1);
            if (lit_en) begin
                check("lit_result", result_o, lit_res);
                check("lit_zero", {31'd0, zero_o}, {31'd0, lit_res == '0});
                check("lit_cout", {31'd0, cout_o}, {31'd0, lit_cout});
                check("lit_overflow", {31'd0, overflow_o}, {31'd0, lit_ovf});
            end
            @(posedge clk);
            #1;
            check("busy_after_done", {31'd0, busy_o}, 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] edge_vals [6];
        logic [W-1:0] ra, rb;
        edge_vals[0] = 32'h0000_0000;
        edge_vals[1] = 32'hFFFF_FFFF;
        edge_vals[2] = 32'h8000_0000;
        edge_vals[3] = 32'h7FFF_FFFF;
        edge_vals[4] = 32'h0000_0001;
        edge_vals[5] = 32'h8000_0001;

        rst_n        = 1'b0;
        start_i      = 1'b0;
        src1_i       = '0;
        src2_i       = '0;
        alu_ctrl_i   = '0;
        bonus_ctrl_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_zero", {31'd0, zero_o}, 32'd1);
        check("rst_cout", {31'd0, cout_o}, 32'd0);
        check("rst_overflow", {31'd0, overflow_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'd5, 32'd3, 4'b0010, 3'd0, 1, 32'd8, 1'b0, 1'b0, 0);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0110, 3'd0, 1, 32'h8000_0000, 1'b0, 1'b1, 0);
        do_op(32'h8000_0000, 32'd1, 4'b0111, 3'd0, 1, 32'd1, 1'b1, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'd1, 4'b0111, 3'd1, 1, 32'd0, 1'b1, 1'b0, 0);
        do_op(32'd7, 32'd7, 4'b0111, 3'd4, 1, 32'd1, 1'b1, 1'b0, 0);
        do_op(32'd7, 32'd7, 4'b0111, 3'd5, 1, 32'd0, 1'b1, 1'b0, 0);
        do_op(32'd7, 32'd7, 4'b0111, 3'd6, 1, 32'd0, 1'b1, 1'b0, 0);
        do_op(32'd3, 32'd9, 4'b0111, 3'd2, 1, 32'd1, 1'b0, 1'b0, 0);
        do_op(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0000, 3'd0, 1, 32'hF000_F000, 1'b0, 1'b0, 1);
        do_op(32'hF0F0_F0F0, 32'h0F00_0000, 4'b0001, 3'd0, 1, 32'hFFF0_F0F0, 1'b0, 1'b0, 0);

        // Reset abort 12 edges into an add
        @(negedge clk);
        src1_i     = 32'd100;
        src2_i     = 32'd23;
        alu_ctrl_i = 4'b0010;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_result", result_o, 32'd0);
        check("abort_zero", {31'd0, zero_o}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd100, 32'd23, 4'b0010, 3'd0, 1, 32'd123, 1'b0, 1'b0, 0);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = ra; end
                2: begin
                    ra = edge_vals[$urandom_range(0, 5)];
                    rb = edge_vals[$urandom_range(0, 5)];
                end
                default: begin
                    ra = 32'($urandom_range(0, 15));
                    rb = 32'($urandom_range(0, 15));
                end
            endcase
            do_op(ra, rb, 4'($urandom), 3'($urandom), 0, '0, 1'b0, 1'b0, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
